// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit sequencer.
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the array for several cycles.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  // Any op that touches HI/LO or the array, hence must wait while busy.
  function automatic logic is_mdu(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MTLO);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// Loadable down-counter; done_o marks the last enabled cycle (count==0).
module mdu_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load wins; decrement only while enabled and never below zero.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = en_i && (count_q == '0);

endmodule

// File: rtl/mdu_sched.sv
// MDU sequencer: issues mult/div to the array, counts latency, owns HI/LO.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic [3:0]  arr_op,
  output logic [31:0] arr_a,
  output logic [31:0] arr_b,
  input  logic [31:0] arr_hi,
  input  logic [31:0] arr_lo,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  mdu_state_e  state_q, state_d;
  logic [3:0]  arr_op_q;
  logic [31:0] arr_a_q, arr_b_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        idle, accept, issue, commit;
  logic [CNT_W-1:0] cnt_val;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && op_valid && !flush;
  assign issue  = accept && is_muldiv(op);
  assign busy   = (state_q == S_BUSY);

  mdu_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (issue),
    .load_val_i (is_mul(op) ? MUL_LD : DIV_LD),
    .en_i       (busy),
    .count_o    (cnt_val),
    .done_o     (commit)
  );

  // Next state: issue enters BUSY, the count==0 cycle returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue)  state_d = S_BUSY;
      S_BUSY:  if (commit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // HI/LO next value: commit of the pending result, or an mt* write when idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (accept && (op == MDU_MTHI)) begin
      hi_d = op_a;
    end else if (accept && (op == MDU_MTLO)) begin
      lo_d = op_a;
    end
  end

  // State, HI/LO, held operands and the pending array result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      arr_op_q  <= '0;
      arr_a_q   <= '0;
      arr_b_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (issue) begin
        pend_hi_q <= arr_hi;
        pend_lo_q <= arr_lo;
        arr_op_q  <= op;
        arr_a_q   <= op_a;
        arr_b_q   <= op_b;
      end
    end
  end

  // The issue cycle feeds the array straight from E; afterwards the held copy.
  assign arr_op = issue ? op   : arr_op_q;
  assign arr_a  = issue ? op_a : arr_a_q;
  assign arr_b  = issue ? op_b : arr_b_q;

  assign stall = op_valid && is_mdu(op) && busy;

  assign rd_data = (accept && (op == MDU_MFHI)) ? hi_q :
                   (accept && (op == MDU_MFLO)) ? lo_q : 32'h0;

  assign hi = hi_q;
  assign lo = lo_q;

  // cnt_val is kept visible for debug; only done is used for control.
  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched with a behavioural mult/div array.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic [3:0]  arr_op;
  logic [31:0] arr_a, arr_b, arr_hi, arr_lo;
  logic        stall, busy;
  logic [31:0] rd_data, hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_sched dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .arr_op   (arr_op),
    .arr_a    (arr_a),
    .arr_b    (arr_b),
    .arr_hi   (arr_hi),
    .arr_lo   (arr_lo),
    .stall    (stall),
    .busy     (busy),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo)
  );

  // Array model: products split HI:LO, divisions give HI=remainder LO=quotient.
  logic [63:0] prod;
  always_comb begin
    prod   = 64'h0;
    arr_hi = 32'h0;
    arr_lo = 32'h0;
    case (arr_op)
      4'd1: begin
        prod = $signed({{32{arr_a[31]}}, arr_a}) * $signed({{32{arr_b[31]}}, arr_b});
        {arr_hi, arr_lo} = prod;
      end
      4'd2: begin
        prod = {32'h0, arr_a} * {32'h0, arr_b};
        {arr_hi, arr_lo} = prod;
      end
      4'd3: if (arr_b != 0) begin
        arr_lo = $signed(arr_a) / $signed(arr_b);
        arr_hi = $signed(arr_a) % $signed(arr_b);
      end
      4'd4: if (arr_b != 0) begin
        arr_lo = arr_a / arr_b;
        arr_hi = arr_a % arr_b;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    op_valid = v;
    op       = o;
    op_a     = a;
    op_b     = b;
    flush    = f;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_rd", rd_data, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_arr_op", {28'h0, arr_op}, 32'h0);
    reset = 1'b0;
    tick();

    // mult -3 * 7: busy for 5 cycles, result visible at T+6
    drive(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mul_issue_stall", {31'h0, stall}, 32'h0);
    check("mul_issue_arr_a", arr_a, 32'hFFFF_FFFD);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mul_busy_T%0d", i), {31'h0, busy}, 32'h1);
      check($sformatf("mul_hi_old_T%0d", i), hi, 32'h0);
      tick();
    end
    check("mul_busy_T6", {31'h0, busy}, 32'h0);
    check("mul_hi", hi, 32'hFFFF_FFFF);
    check("mul_lo", lo, 32'hFFFF_FFEB);

    // divu 100/7 followed by a stalled mflo
    drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b1, 4'd6, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("divu_stall_T%0d", i), {31'h0, stall}, 32'h1);
      tick();
    end
    check("divu_stall_T11", {31'h0, stall}, 32'h0);
    check("divu_mflo", rd_data, 32'h0000_000E);
    check("divu_hi", hi, 32'h0000_0002);
    tick();

    // mthi then mfhi; LO untouched
    drive(1'b1, 4'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("mthi_rd_zero", rd_data, 32'h0);
    tick();
    drive(1'b1, 4'd5, 32'h0, 32'h0, 1'b0);
    check("mfhi_rd", rd_data, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo, 32'h0000_000E);
    tick();

    // flushed mult does nothing; flushed mtlo does nothing
    drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b1);
    tick();
    check("flush_no_busy", {31'h0, busy}, 32'h0);
    drive(1'b1, 4'd8, 32'h1234_5678, 32'h0, 1'b1);
    tick();
    check("flush_hi_kept", hi, 32'hDEAD_BEEF);
    check("flush_lo_kept", lo, 32'h0000_000E);

    // mult 5*6 with a flush pulse mid-BUSY; invalid op never stalls
    drive(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
    tick();                                           // T+1
    drive(1'b1, 4'd9, 32'h0, 32'h0, 1'b0);
    check("inv_no_stall", {31'h0, stall}, 32'h0);
    tick();                                           // T+2
    drive(1'b1, 4'd6, 32'h0, 32'h0, 1'b1);
    check("flush_stall_formula", {31'h0, stall}, 32'h1);
    check("flush_mid_busy", {31'h0, busy}, 32'h1);
    check("flush_mid_rd", rd_data, 32'h0);
    tick();                                           // T+3
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    tick();                                           // T+4
    tick();                                           // T+5
    check("flush_busy_T5", {31'h0, busy}, 32'h1);
    check("flush_lo_T5", lo, 32'h0000_000E);
    tick();                                           // T+6
    check("flush_busy_T6", {31'h0, busy}, 32'h0);
    check("flush_commit_hi", hi, 32'h0);
    check("flush_commit_lo", lo, 32'h0000_001E);

    // async reset 3 cycles into a div, checked before any clock edge
    drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b1, 4'd5, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_stall", {31'h0, stall}, 32'h0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_arr_op", {28'h0, arr_op}, 32'h0);
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    tick();

    // back-to-back mult (3*4) then multu (FFFFFFFF*2)
    drive(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
    tick();                                           // T+1
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("b2b_stall_T%0d", i), {31'h0, stall}, 32'h1);
      check($sformatf("b2b_arr_a_T%0d", i), arr_a, 32'd3);
      tick();
    end
    // T+6: second op issues
    check("b2b_issue_stall", {31'h0, stall}, 32'h0);
    check("b2b_first_lo", lo, 32'h0000_000C);
    check("b2b_issue_arr_a", arr_a, 32'hFFFF_FFFF);
    tick();                                           // T+7
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 7; i <= 11; i++) begin
      check($sformatf("b2b_busy_T%0d", i), {31'h0, busy}, 32'h1);
      check($sformatf("b2b_hi_old_T%0d", i), hi, 32'h0);
      tick();
    end
    check("b2b_busy_T12", {31'h0, busy}, 32'h0);
    check("b2b_hi", hi, 32'h0000_0001);
    check("b2b_lo", lo, 32'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
